// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: LC-3b memory access sequencer.
// Arbitrates trap-vector, data and fetch requesters, loads the MAR through its
// mux, then runs the memory ready handshake with byte-lane steering,
// word-misalignment detection and an access timeout.
module mem_access_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trap_req,
   input  logic        data_req,
   input  logic        data_we,
   input  logic        data_byte,
   input  logic [15:0] data_wdata,
   input  logic        fetch_req,
   input  logic [15:0] mar_q,
   output logic        ld_mar,
   output logic        mar_sel,
   output logic        mem_en,
   output logic        mem_we,
   output logic [1:0]  mem_wmask,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        ack_trap,
   output logic        ack_data,
   output logic        ack_fetch,
   output logic [15:0] rdata,
   output logic        err
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_TRAP, SRC_DATA, SRC_FETCH} src_t;

   state_t        state_q, state_d;
   src_t          src_q, src_d;
   logic          we_q, byte_q;
   logic [15:0]   wdata_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          grant, cap, cnt_inc;
   logic          word_acc, misal, is_store;
   logic [7:0]    lane;

   assign word_acc = (src_q != SRC_DATA) || !byte_q;
   assign misal    = word_acc && mar_q[0];
   assign is_store = (src_q == SRC_DATA) && we_q;
   assign lane     = mar_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

   // Next-state, arbitration and all handshake outputs
   always_comb begin
      state_d   = state_q;
      src_d     = SRC_NONE;
      grant     = 1'b0;
      cap       = 1'b0;
      cnt_inc   = 1'b0;
      rdata_d   = '0;
      err_d     = 1'b0;
      ld_mar    = 1'b0;
      mar_sel   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_wmask = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      ack_trap  = 1'b0;
      ack_data  = 1'b0;
      ack_fetch = 1'b0;
      rdata     = '0;
      err       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (trap_req) begin
               src_d = SRC_TRAP;
               grant = 1'b1;
            end else if (data_req) begin
               src_d = SRC_DATA;
               grant = 1'b1;
            end else if (fetch_req) begin
               src_d = SRC_FETCH;
               grant = 1'b1;
            end
            if (grant) state_d = LOAD;
         end
         LOAD: begin
            ld_mar  = 1'b1;
            mar_sel = (src_q != SRC_TRAP);
            state_d = ACCESS;
         end
         ACCESS: begin
            // The MAR holds the new address only from this cycle, so the
            // alignment check gates mem_en here rather than in LOAD.
            if (misal) begin
               cap     = 1'b1;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               mem_en   = 1'b1;
               mem_addr = {mar_q[15:1], 1'b0};
               mem_we   = is_store;
               if (is_store) begin
                  if (byte_q) begin
                     mem_wmask = mar_q[0] ? 2'b10 : 2'b01;
                     mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
                  end else begin
                     mem_wmask = 2'b11;
                     mem_wdata = wdata_q;
                  end
               end
               if (mem_ready) begin
                  cap     = 1'b1;
                  state_d = DONE;
                  if (!is_store) rdata_d = byte_q && (src_q == SRC_DATA) ?
                                           {{8{lane[7]}}, lane} : mem_rdata;
               end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                  cap     = 1'b1;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DONE: begin
            ack_trap  = (src_q == SRC_TRAP);
            ack_data  = (src_q == SRC_DATA);
            ack_fetch = (src_q == SRC_FETCH);
            rdata     = rdata_q;
            err       = err_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, grant capture, timeout counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= SRC_NONE;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_inc ? cnt_q + 1'b1 : '0;
         if (grant) begin
            src_q   <= src_d;
            we_q    <= data_we;
            byte_q  <= data_byte;
            wdata_q <= data_wdata;
         end
         if (cap) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
         end else if (state_q == DONE) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with an external
// MAR model and a memory responder of programmable ready delay.
module tb_mem_access_ctrl;

   localparam int unsigned T = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trap_req = 1'b0, data_req = 1'b0, fetch_req = 1'b0;
   logic        data_we = 1'b0, data_byte = 1'b0;
   logic [15:0] data_wdata = '0;
   logic [15:0] mar_q = '0;
   logic        ld_mar, mar_sel, mem_en, mem_we;
   logic [1:0]  mem_wmask;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        ack_trap, ack_data, ack_fetch;
   logic [15:0] rdata;
   logic        err;

   mem_access_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .data_req(data_req),
      .data_we(data_we), .data_byte(data_byte), .data_wdata(data_wdata),
      .fetch_req(fetch_req), .mar_q(mar_q), .ld_mar(ld_mar), .mar_sel(mar_sel),
      .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .ack_trap(ack_trap), .ack_data(ack_data),
      .ack_fetch(ack_fetch), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 trap, 1 data, 2 fetch
      logic [15:0] rdata;
      logic        err;
      logic        mem;
      logic        sel;
      logic        we;
      logic [1:0]  mask;
      logic [15:0] wdata;
      logic [15:0] addr;
      int          issue;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          en_cnt = 0;
   int          ready_after = 0;
   logic [15:0] trap_addr = '0;
   logic [15:0] adder_addr = '0;

   // External MAR register and cycle counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_mar) mar_q <= mar_sel ? adder_addr : trap_addr;
      if (mem_en && !mem_ready) en_cnt = en_cnt + 1;
   end

   // Memory responder plus scoreboard checking, away from the rising edge
   always @(negedge clk) begin
      mem_ready = mem_en && (en_cnt >= ready_after);
      if (rst_n) begin
         if (ld_mar) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL ld_mar_unexpected cyc=%0d", cyc);
            end else if (mar_sel !== sb[0].sel) begin
               errors++; $display("FAIL mar_sel got=%b exp=%b", mar_sel, sb[0].sel);
            end
         end
         if (mem_en) begin
            checks++;
            if (sb.size() == 0 || !sb[0].mem) begin
               errors++; $display("FAIL mem_en_unexpected cyc=%0d", cyc);
            end else if (mem_addr !== sb[0].addr || mem_we !== sb[0].we ||
                         mem_wmask !== sb[0].mask ||
                         (sb[0].we && mem_wdata !== sb[0].wdata)) begin
               errors++;
               $display("FAIL mem_bus got addr=%h we=%b mask=%b wdata=%h exp addr=%h we=%b mask=%b wdata=%h",
                        mem_addr, mem_we, mem_wmask, mem_wdata,
                        sb[0].addr, sb[0].we, sb[0].mask, sb[0].wdata);
            end
         end
         checks++;
         if (int'(ack_trap) + int'(ack_data) + int'(ack_fetch) > 1) begin
            errors++; $display("FAIL multi_ack got=%b%b%b exp=one", ack_trap, ack_data, ack_fetch);
         end else if (ack_trap || ack_data || ack_fetch) begin
            int k;
            k = ack_trap ? 0 : (ack_data ? 1 : 2);
            if (sb.size() == 0) begin
               errors++; $display("FAIL ack_unexpected got=%0d exp=none", k);
            end else begin
               if (k != sb[0].kind || rdata !== sb[0].rdata || err !== sb[0].err ||
                   (sb[0].lat >= 0 && cyc - sb[0].issue != sb[0].lat)) begin
                  errors++;
                  $display("FAIL ack got kind=%0d rdata=%h err=%b lat=%0d exp kind=%0d rdata=%h err=%b lat=%0d",
                           k, rdata, err, cyc - sb[0].issue,
                           sb[0].kind, sb[0].rdata, sb[0].err, sb[0].lat);
               end
               void'(sb.pop_front());
            end
            en_cnt = 0;
            if (k == 0) trap_req = 1'b0;
            if (k == 1) data_req = 1'b0;
            if (k == 2) fetch_req = 1'b0;
         end else if (rdata !== 16'h0 || err !== 1'b0) begin
            errors++; $display("FAIL idle_result got rdata=%h err=%b exp=0", rdata, err);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Reference behaviour of one transaction, computed from the stimulus
   task automatic push_exp(input int kind, input int lat);
      exp_t        e;
      logic [15:0] a;
      logic        st, bt, mis, to;
      a   = (kind == 0) ? trap_addr : adder_addr;
      st  = (kind == 1) && data_we;
      bt  = (kind == 1) && data_byte;
      mis = !bt && a[0];
      to  = !mis && (ready_after >= int'(T));
      e.kind  = kind;
      e.err   = mis || to;
      e.mem   = !mis;
      e.sel   = (kind != 0);
      e.we    = st;
      e.addr  = {a[15:1], 1'b0};
      e.mask  = !st ? 2'b00 : (!bt ? 2'b11 : (a[0] ? 2'b10 : 2'b01));
      e.wdata = bt ? {data_wdata[7:0], data_wdata[7:0]} : data_wdata;
      if (e.err || st)  e.rdata = 16'h0;
      else if (bt)      e.rdata = a[0] ? {{8{mem_rdata[15]}}, mem_rdata[15:8]}
                                       : {{8{mem_rdata[7]}}, mem_rdata[7:0]};
      else              e.rdata = mem_rdata;
      e.issue = cyc;
      e.lat   = lat;
      sb.push_back(e);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick(); n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
         sb.delete();
         trap_req = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
      end
      tick();
   endtask

   task automatic do_data(input logic we, input logic bt, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] rd, input int lat);
      tick();
      adder_addr = a; data_we = we; data_byte = bt; data_wdata = wd; mem_rdata = rd;
      data_req = 1'b1;
      push_exp(1, lat);
      wait_drain();
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({ld_mar, mar_sel, mem_en, mem_we, mem_wmask, mem_addr, mem_wdata,
           ack_trap, ack_data, ack_fetch, rdata, err} !== '0) begin
         errors++;
         $display("FAIL %s got en=%b ld=%b addr=%h ack=%b%b%b rdata=%h err=%b exp=all0",
                  name, mem_en, ld_mar, mem_addr, ack_trap, ack_data, ack_fetch, rdata, err);
      end
   endtask

   task automatic test_reset();
      #1 check_outputs_zero("reset_state");
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_outputs_zero("post_reset_idle");
   endtask

   task automatic test_fetch();
      tick();
      adder_addr = 16'h3000; mem_rdata = 16'h1234; ready_after = 0;
      fetch_req = 1'b1;
      push_exp(2, 3);
      wait_drain();
   endtask

   task automatic test_priority();
      tick();
      trap_addr = 16'h0050; adder_addr = 16'h2000; mem_rdata = 16'h5A5A;
      data_we = 1'b0; data_byte = 1'b0;
      trap_req = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
      push_exp(0, 3);
      push_exp(1, 7);
      push_exp(2, 11);
      wait_drain();
   endtask

   task automatic test_byte();
      do_data(1'b0, 1'b1, 16'h4001, 16'h0000, 16'h80FF, 3);
      do_data(1'b0, 1'b1, 16'h4000, 16'h0000, 16'h80FF, 3);
      do_data(1'b0, 1'b1, 16'h4000, 16'h0000, 16'h7F12, 3);
      do_data(1'b1, 1'b1, 16'h4001, 16'h00AB, 16'hFFFF, 3);
      do_data(1'b1, 1'b1, 16'h4000, 16'h00CD, 16'hFFFF, 3);
      do_data(1'b1, 1'b0, 16'h4002, 16'hBEEF, 16'hFFFF, 3);
   endtask

   task automatic test_misaligned();
      do_data(1'b0, 1'b0, 16'h4001, 16'h0000, 16'h1111, 3);
      do_data(1'b1, 1'b0, 16'h4003, 16'h2222, 16'h1111, 3);
      tick();
      adder_addr = 16'h3001; fetch_req = 1'b1;
      push_exp(2, 3);
      wait_drain();
   endtask

   task automatic test_timeout();
      ready_after = 100;
      do_data(1'b0, 1'b0, 16'h6000, 16'h0000, 16'h9999, 2 + int'(T));
      ready_after = int'(T) - 1;
      do_data(1'b0, 1'b0, 16'h6002, 16'h0000, 16'h8888, 2 + int'(T));
      ready_after = 2;
      do_data(1'b0, 1'b0, 16'h6004, 16'h0000, 16'h7777, 5);
      ready_after = 0;
   endtask

   task automatic test_ignore_after_grant();
      tick();
      adder_addr = 16'h5000; data_we = 1'b1; data_byte = 1'b0; data_wdata = 16'h1111;
      data_req = 1'b1;
      push_exp(1, 3);
      tick();
      data_we = 1'b0; data_byte = 1'b1; data_wdata = 16'h2222;
      wait_drain();
   endtask

   task automatic test_reset_mid();
      tick();
      adder_addr = 16'h3100; mem_rdata = 16'hCAFE; ready_after = 100;
      fetch_req = 1'b1;
      push_exp(2, -1);
      tick(); tick();
      #1 rst_n = 1'b0;
      #1 check_outputs_zero("reset_mid_access");
      sb.delete();
      en_cnt = 0; ready_after = 0;
      push_exp(2, -1);
      #1 rst_n = 1'b1;
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_byte();
      test_misaligned();
      test_timeout();
      test_ignore_after_grant();
      test_reset_mid();
      test_fetch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
